execute_cc_stage: RTL and testbench
===================================

# execute_cc_stage

Registered execute stage for the Y86-64 SEQ datapath, directly downstream of decode and wrapping the 64-bit adder/ALU path.
- Selects ALU operands and function from icode/ifun, computes valE and holds the condition-code register (ZF/SF/OF).
- Evaluates Cnd for jXX/cmovXX.
- Presents the result through a one-entry valid/ready output register to memory/write-back.

## Interface
- W, 64, datapath width (only 64 is supported).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode bundle valid.
- in_ready  out  1  stage can accept; equals !out_valid || out_ready.
- in_icode  in  4  instruction code.
- in_ifun  in  4  function code.
- in_valA, in_valB, in_valC  in  W  register and constant operands.
- out_valid  out  1  result register holds a valid entry.
- out_ready  in  1  downstream accepts.
- out_icode  out  4  registered icode.
- out_valE  out  W  registered ALU result.
- out_cnd  out  1  registered condition result.
- out_err  out  1  invalid icode/ifun flag.
- cc_zf, cc_sf, cc_of  out  1  current condition codes.

## Operation
- Accept occurs when in_valid && in_ready.
- On accept, the output register loads icode, valE, cnd and err, and out_valid is set.
- Otherwise, if out_ready, out_valid clears.
- Operand and function selection (aluB op aluA):
  - OPq (6): valB op valA, op from ifun: 0 add, 1 sub (valB-valA), 2 and, 3 xor.
  - rrmovq/cmovXX (2): 0+valA.
  - irmovq (3): 0+valC.
  - rmmovq (4), mrmovq (5): valB+valC.
  - call (8), pushq (A): valB+(-8).
  - ret (9), popq (B): valB+8.
  - halt (0), nop (1), jXX (7): valE=0.
- Arithmetic is modulo 2^64; carry out is discarded.
- Condition-code update, on accepted OPq with ifun≤3 only:
  - ZF = (valE==0).
  - SF = valE[63].
  - Add OF: aluA[63]==aluB[63] && valE[63]!=aluB[63].
  - Sub OF: aluA[63]!=aluB[63] && valE[63]!=aluB[63].
  - and/xor: OF=0.
- Cnd uses the CC value before this instruction's update:
  - ifun 0: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&&!ZF.
- out_cnd is computed for icode 2 and 7 only; it is 0 for every other icode.
- out_err=1 in these cases:
  - icode>B.
  - OPq with ifun>3.
  - icode 2/7 with ifun>6.
- When out_err=1: valE=0, cnd=0, CC unchanged.

## Timing
- Latency is 1 cycle: a bundle accepted at edge N appears on out_* after edge N.
- Throughput is one bundle per cycle while out_ready=1.
- When out_valid && !out_ready, out_* hold stable and in_ready=0.
- The same-cycle drain-and-accept case is allowed.
- A CC update from an OPq accepted at edge N is visible to a jXX/cmov accepted at edge N+1 (no bypass needed).
- Reset (asynchronous, any cycle including mid-stall):
  - out_valid=0, out_icode=0, out_valE=0, out_cnd=0, out_err=0.
  - ZF=1, SF=0, OF=0.
  - An in-flight entry is discarded.
- After rst_n rises, the first accept can occur at the first rising edge.
- Condition codes change only on accepted valid OPq. They do not change during stalls or on err.

## Test plan
- OPq add, valA=0xCCCCCCCCCCCCCCCC, valB=0xAAAAAAAAAAAAAAAA -> out_valE=0x7777777777777776, ZF=0, SF=0, OF=1, out_valid one cycle later.
- OPq add, valA=0xF0F0F0F0F0F0F0F0, valB=0x0F0F0F0F0F0F0F0F -> out_valE=0xFFFFFFFFFFFFFFFF, SF=1, ZF=0, OF=0.
- Back-to-back sequence, checking each result in order:
  - OPq add valA=2, valB=-47 -> valE=0xFFFFFFFFFFFFFFD3, SF=1.
  - Next cycle jXX ifun=1 (le) -> cnd=1.
  - Then jXX ifun=5 (ge) -> cnd=0.
- OPq sub, valA=valB=0x8000000000000000 -> valE=0, ZF=1, OF=0.
  - Following cmovXX ifun=3 (e) -> cnd=1, valE=valA.
  - Following cmovXX ifun=4 (ne) -> cnd=0.
- Backpressure and error cases:
  - out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* frozen, CC unchanged.
  - OPq ifun=7 -> out_err=1, valE=0, CC unchanged.
  - pushq valB=0x100 -> valE=0xF8.
- Reset handling:
  - Assert rst_n=0 mid-stall, asynchronously between edges -> out_valid=0 and ZF/SF/OF=1/0/0 immediately.
  - After release, irmovq valC=0x1234 -> valE=0x1234.

Source files
------------

// File: rtl/execute_cc_stage.sv
// Y86-64 SEQ execute stage: ALU operand/function select, condition-code register and Cnd,
// with the result held in a one-entry valid/ready output register.
module execute_cc_stage #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_icode,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_valA,
    input  logic [W-1:0] in_valB,
    input  logic [W-1:0] in_valC,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_icode,
    output logic [W-1:0] out_valE,
    output logic         out_cnd,
    output logic         out_err,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);

    localparam logic [3:0] IcHalt   = 4'h0;
    localparam logic [3:0] IcNop    = 4'h1;
    localparam logic [3:0] IcCmov   = 4'h2;
    localparam logic [3:0] IcIrmovq = 4'h3;
    localparam logic [3:0] IcRmmovq = 4'h4;
    localparam logic [3:0] IcMrmovq = 4'h5;
    localparam logic [3:0] IcOpq    = 4'h6;
    localparam logic [3:0] IcJxx    = 4'h7;
    localparam logic [3:0] IcCall   = 4'h8;
    localparam logic [3:0] IcRet    = 4'h9;
    localparam logic [3:0] IcPushq  = 4'hA;
    localparam logic [3:0] IcPopq   = 4'hB;

    logic [W-1:0] alu_a, alu_b, alu_res, val_e;
    logic [1:0]   alu_fun;
    logic         uses_cnd, err, cond, cnd, of_res, lt;
    logic         accept, cc_load;

    logic         out_valid_q, out_valid_d;
    logic [3:0]   out_icode_q, out_icode_d;
    logic [W-1:0] out_val_e_q, out_val_e_d;
    logic         out_cnd_q, out_cnd_d;
    logic         out_err_q, out_err_d;
    logic         zf_q, zf_d, sf_q, sf_d, of_q, of_d;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // Operand/function select; the ALU always computes aluB op aluA.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_fun  = 2'd0;
        uses_cnd = 1'b0;
        err      = 1'b0;
        case (in_icode)
            IcHalt, IcNop: ;
            IcCmov: begin
                alu_a    = in_valA;
                uses_cnd = 1'b1;
            end
            IcIrmovq: alu_a = in_valC;
            IcRmmovq, IcMrmovq: begin
                alu_a = in_valC;
                alu_b = in_valB;
            end
            IcOpq: begin
                alu_a   = in_valA;
                alu_b   = in_valB;
                alu_fun = in_ifun[1:0];
                err     = (in_ifun > 4'd3);
            end
            IcJxx: uses_cnd = 1'b1;
            IcCall, IcPushq: begin
                alu_a = ~W'(7);
                alu_b = in_valB;
            end
            IcRet, IcPopq: begin
                alu_a = W'(8);
                alu_b = in_valB;
            end
            default: err = 1'b1;
        endcase
        if (uses_cnd && (in_ifun > 4'd6)) begin
            err = 1'b1;
        end
    end

    always_comb begin
        case (alu_fun)
            2'd0:    alu_res = alu_b + alu_a;
            2'd1:    alu_res = alu_b - alu_a;
            2'd2:    alu_res = alu_b & alu_a;
            default: alu_res = alu_b ^ alu_a;
        endcase
        case (alu_fun)
            2'd0:    of_res = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_b[W-1]);
            2'd1:    of_res = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_b[W-1]);
            default: of_res = 1'b0;
        endcase
    end

    // Cnd is evaluated against the CC value held before this instruction.
    always_comb begin
        lt = sf_q ^ of_q;
        case (in_ifun)
            4'd0:    cond = 1'b1;
            4'd1:    cond = lt | zf_q;
            4'd2:    cond = lt;
            4'd3:    cond = zf_q;
            4'd4:    cond = ~zf_q;
            4'd5:    cond = ~lt;
            4'd6:    cond = ~lt & ~zf_q;
            default: cond = 1'b0;
        endcase
        cnd     = uses_cnd & ~err & cond;
        val_e   = err ? '0 : alu_res;
        cc_load = accept & (in_icode == IcOpq) & ~err;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_icode_d = out_icode_q;
        out_val_e_d = out_val_e_q;
        out_cnd_d   = out_cnd_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_icode_d = in_icode;
            out_val_e_d = val_e;
            out_cnd_d   = cnd;
            out_err_d   = err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (cc_load) begin
            zf_d = (alu_res == '0);
            sf_d = alu_res[W-1];
            of_d = of_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_icode_q <= 4'h0;
            out_val_e_q <= '0;
            out_cnd_q   <= 1'b0;
            out_err_q   <= 1'b0;
            zf_q        <= 1'b1;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_icode_q <= out_icode_d;
            out_val_e_q <= out_val_e_d;
            out_cnd_q   <= out_cnd_d;
            out_err_q   <= out_err_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
            of_q        <= of_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_icode = out_icode_q;
    assign out_valE  = out_val_e_q;
    assign out_cnd   = out_cnd_q;
    assign out_err   = out_err_q;
    assign cc_zf     = zf_q;
    assign cc_sf     = sf_q;
    assign cc_of     = of_q;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Bench for execute_cc_stage: directed test-plan sequences with literal expectations, then
// randomized traffic, all cross-checked every cycle against an instruction-level model.
module tb_execute_cc_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_icode, in_ifun, out_icode;
    logic [63:0] in_valA, in_valB, in_valC, out_valE;
    logic        out_cnd, out_err, cc_zf, cc_sf, cc_of;

    int errors = 0;
    int checks = 0;

    // Architectural model state
    bit          m_valid = 0, m_cnd = 0, m_err = 0;
    bit          m_zf = 1, m_sf = 0, m_of = 0;
    logic [3:0]  m_icode = '0;
    logic [63:0] m_vale = '0;

    execute_cc_stage #(.W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_icode  (in_icode),
        .in_ifun   (in_ifun),
        .in_valA   (in_valA),
        .in_valB   (in_valB),
        .in_valC   (in_valC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_icode (out_icode),
        .out_valE  (out_valE),
        .out_cnd   (out_cnd),
        .out_err   (out_err),
        .cc_zf     (cc_zf),
        .cc_sf     (cc_sf),
        .cc_of     (cc_of)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_of(input logic [3:0] fn, input bit zf, sf, of);
        bit less;
        less = (sf != of);
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return less || zf;
            4'd2:    return less;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !less;
            4'd6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level semantics; overflow from a sign-extended 65-bit result.
    task automatic model_exec(input logic [3:0] ic, fn, input logic [63:0] a, b, c,
                              input bit zf, sf, of, output logic [63:0] ve,
                              output bit cnd, er, nzf, nsf, nof);
        logic signed [64:0] wide;
        ve = '0; cnd = 0; nzf = zf; nsf = sf; nof = of;
        er = (ic > 4'd11) || (ic == 4'd6 && fn > 4'd3) || ((ic == 4'd2 || ic == 4'd7) && fn > 4'd6);
        if (!er) begin
            case (ic)
                4'd2: begin ve = a; cnd = cond_of(fn, zf, sf, of); end
                4'd3: ve = c;
                4'd4, 4'd5: ve = b + c;
                4'd7: cnd = cond_of(fn, zf, sf, of);
                4'd8, 4'd10: ve = b - 64'd8;
                4'd9, 4'd11: ve = b + 64'd8;
                4'd6: begin
                    nof = 0;
                    case (fn)
                        4'd0: begin
                            wide = $signed({b[63], b}) + $signed({a[63], a});
                            ve = wide[63:0];
                            nof = (wide[64] != wide[63]);
                        end
                        4'd1: begin
                            wide = $signed({b[63], b}) - $signed({a[63], a});
                            ve = wide[63:0];
                            nof = (wide[64] != wide[63]);
                        end
                        4'd2: ve = b & a;
                        default: ve = b ^ a;
                    endcase
                    nzf = (ve == 0);
                    nsf = ($signed(ve) < 0);
                end
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_icode = '0; m_vale = '0; m_cnd = 0; m_err = 0;
        m_zf = 1; m_sf = 0; m_of = 0;
    endtask

    // Model step on every edge, then compare all outputs just after it.
    always @(posedge clk) begin
        logic [63:0] ve;
        bit cn, er, nz, ns, no;
        if (!rst_n) begin
            model_reset();
        end else begin
            chk("in_ready", in_ready, (!m_valid || out_ready));
            if (in_valid && (!m_valid || out_ready)) begin
                model_exec(in_icode, in_ifun, in_valA, in_valB, in_valC, m_zf, m_sf, m_of,
                           ve, cn, er, nz, ns, no);
                m_valid = 1; m_icode = in_icode; m_vale = ve; m_cnd = cn; m_err = er;
                m_zf = nz; m_sf = ns; m_of = no;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_icode", out_icode, m_icode);
        chk("out_valE", out_valE, m_vale);
        chk("out_cnd", out_cnd, m_cnd);
        chk("out_err", out_err, m_err);
        chk("cc_zf", cc_zf, m_zf);
        chk("cc_sf", cc_sf, m_sf);
        chk("cc_of", cc_of, m_of);
    end

    task automatic send(input logic [3:0] ic, fn, input logic [63:0] a, b, c);
        @(negedge clk);
        in_valid = 1; in_icode = ic; in_ifun = fn; in_valA = a; in_valB = b; in_valC = c;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_valE", out_valE, 64'h0);
        chk("rst zf", cc_zf, 1'b1);
        chk("rst sf", cc_sf, 1'b0);
        chk("rst of", cc_of, 1'b0);
    endtask

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 1;
        in_icode = '0; in_ifun = '0; in_valA = '0; in_valB = '0; in_valC = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("init out_valid", out_valid, 1'b0);
        chk("init zf", cc_zf, 1'b1);
        chk("init out_icode", out_icode, 4'h0);
        @(negedge clk);
        rst_n = 1;

        send(4'h6, 4'h0, 64'hCCCC_CCCC_CCCC_CCCC, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0);
        chk("add1 valE", out_valE, 64'h7777_7777_7777_7776);
        chk("add1 valid", out_valid, 1'b1);
        chk("add1 zf", cc_zf, 1'b0);
        chk("add1 sf", cc_sf, 1'b0);
        chk("add1 of", cc_of, 1'b1);

        send(4'h6, 4'h0, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0);
        chk("add2 valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("add2 sf", cc_sf, 1'b1);
        chk("add2 zf", cc_zf, 1'b0);
        chk("add2 of", cc_of, 1'b0);

        send(4'h6, 4'h0, 64'd2, 64'hFFFF_FFFF_FFFF_FFD1, 64'h0);
        chk("add3 valE", out_valE, 64'hFFFF_FFFF_FFFF_FFD3);
        chk("add3 sf", cc_sf, 1'b1);
        send(4'h7, 4'h1, 64'h0, 64'h0, 64'h0);
        chk("jle cnd", out_cnd, 1'b1);
        send(4'h7, 4'h5, 64'h0, 64'h0, 64'h0);
        chk("jge cnd", out_cnd, 1'b0);

        send(4'h6, 4'h1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0);
        chk("sub valE", out_valE, 64'h0);
        chk("sub zf", cc_zf, 1'b1);
        chk("sub of", cc_of, 1'b0);
        send(4'h2, 4'h3, 64'h55, 64'h0, 64'h0);
        chk("cmove cnd", out_cnd, 1'b1);
        chk("cmove valE", out_valE, 64'h55);
        send(4'h2, 4'h4, 64'h66, 64'h0, 64'h0);
        chk("cmovne cnd", out_cnd, 1'b0);

        send(4'h6, 4'h0, 64'd1, 64'd1, 64'h0);
        chk("pre-stall valE", out_valE, 64'd2);
        @(negedge clk);
        out_ready = 0; in_ifun = 4'h1; in_valA = 64'd5; in_valB = 64'd3;
        repeat (3) begin
            @(posedge clk);
            #2;
            chk("stall in_ready", in_ready, 1'b0);
            chk("stall valid", out_valid, 1'b1);
            chk("stall valE", out_valE, 64'd2);
            chk("stall zf", cc_zf, 1'b0);
            chk("stall sf", cc_sf, 1'b0);
        end
        @(negedge clk);
        out_ready = 1;
        @(posedge clk);
        #2;
        chk("post-stall valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("post-stall sf", cc_sf, 1'b1);

        send(4'h6, 4'h7, 64'd9, 64'd9, 64'h0);
        chk("err flag", out_err, 1'b1);
        chk("err valE", out_valE, 64'h0);
        chk("err sf kept", cc_sf, 1'b1);
        chk("err zf kept", cc_zf, 1'b0);
        send(4'hA, 4'h0, 64'h0, 64'h100, 64'h0);
        chk("pushq valE", out_valE, 64'hF8);
        chk("pushq err", out_err, 1'b0);

        @(negedge clk);
        in_valid = 0; out_ready = 0;
        @(posedge clk);
        #3;
        do_reset();
        @(negedge clk);
        rst_n = 1; out_ready = 1;
        send(4'h3, 4'h0, 64'h0, 64'h0, 64'h1234);
        chk("irmovq valE", out_valE, 64'h1234);
        chk("irmovq valid", out_valid, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: in_icode = 4'h6;
                1: in_icode = 4'h7;
                2: in_icode = 4'h2;
                default: in_icode = 4'($urandom_range(0, 15));
            endcase
            in_ifun = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 6));
            in_valA = rnd_op();
            in_valB = ($urandom_range(0, 7) == 0) ? in_valA : rnd_op();
            in_valC = rnd_op();
            if ($urandom_range(0, 299) == 0) begin
                #2;
                do_reset();
                #1;
                rst_n = 1;
            end
        end

        @(negedge clk);
        in_valid = 0;
        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
